// File: rtl/apb_requester_engine.sv
// APB requester: takes one command over valid/ready, runs SETUP/ACCESS on the APB bus and
// returns read data and status over valid/ready, with an optional per-transfer ACCESS timeout.
`timescale 1ns/1ps
module apb_requester_engine #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  pclk,
    input  logic                  preset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr,
    output logic [1:0]            dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready; the sender holds
    // valid and payload stable until then, and ready never depends combinationally on valid.
    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            w_cmd_fire;
    logic            w_timeout;

    assign w_cmd_fire = cmd_valid && cmd_ready;
    // pready has priority over the timeout, so this is only consulted when pready is low
    assign w_timeout  = (TIMEOUT_CYCLES > 0) && !pready && (r_cnt == TO_LAST);
    assign dbg_state  = r_state;

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            cmd_ready   <= 1'b0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (w_cmd_fire) begin
                        cmd_ready <= 1'b0;
                        psel      <= 1'b1;
                        penable   <= 1'b0;
                        paddr     <= cmd_addr;
                        pwrite    <= cmd_write;
                        pwdata    <= cmd_write ? cmd_wdata : '0;
                        r_cnt     <= '0;
                        r_state   <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    penable <= 1'b1;
                    r_state <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (pready || w_timeout) begin
                        rsp_rdata   <= (pready && !pwrite) ? prdata : '0;
                        rsp_err     <= pready ? pslverr : 1'b1;
                        rsp_timeout <= !pready;
                        rsp_valid   <= 1'b1;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        pwrite      <= 1'b0;
                        paddr       <= '0;
                        pwdata      <= '0;
                        r_state     <= S_RESP;
                    end else if (r_cnt != {CW{1'b1}}) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_requester_engine.sv
// Directed bench for apb_requester_engine: behavioural APB completer with configurable wait
// states, error and stall, plus a second engine with the timeout disabled.
`timescale 1ns/1ps
module tb_apb_requester_engine;

    logic        pclk = 1'b0;
    logic        preset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_ready = 1'b1;
    logic        cmd_ready, rsp_valid, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata, paddr, pwdata, prdata;
    logic        psel, penable, pwrite, pready, pslverr;
    logic [1:0]  dbg_state;

    logic        cmd_valid2 = 1'b0;
    logic        cmd_ready2, rsp_valid2, rsp_err2, rsp_timeout2;
    logic [31:0] rsp_rdata2, paddr2, pwdata2;
    logic        psel2, penable2, pwrite2;
    logic [1:0]  dbg_state2;

    int          check_cnt = 0;
    int          err_cnt = 0;

    int          cfg_wait = 0;
    logic        cfg_err = 1'b0;
    logic        cfg_stall = 1'b0;
    logic [7:0]  wcnt;
    logic [31:0] mem [0:255];

    always #5 pclk = ~pclk;

    apb_requester_engine #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .pclk(pclk), .preset_n(preset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr), .dbg_state(dbg_state)
    );

    apb_requester_engine #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(0)) dut_noto (
        .pclk(pclk), .preset_n(preset_n),
        .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid2), .rsp_ready(1'b1), .rsp_rdata(rsp_rdata2),
        .rsp_err(rsp_err2), .rsp_timeout(rsp_timeout2),
        .paddr(paddr2), .psel(psel2), .penable(penable2), .pwrite(pwrite2), .pwdata(pwdata2),
        .prdata(32'h0), .pready(1'b0), .pslverr(1'b0), .dbg_state(dbg_state2)
    );

    // completer: pready after cfg_wait extra ACCESS cycles unless stalled
    assign pready  = psel && penable && !cfg_stall && (int'(wcnt) == cfg_wait);
    assign pslverr = pready && cfg_err;
    assign prdata  = mem[paddr[9:2]];

    always_ff @(posedge pclk) begin
        if (psel && penable && !pready) wcnt <= wcnt + 8'd1;
        else                            wcnt <= 8'd0;
        if (pready && pwrite) mem[paddr[9:2]] <= pwdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // called at a negedge; returns at the negedge of the SETUP cycle
    task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
        logic done;
        done = 1'b0;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        for (int i = 0; i < 50 && !done; i++) begin
            if (cmd_ready) begin
                @(posedge pclk);
                done = 1'b1;
            end else begin
                @(negedge pclk);
            end
        end
        check("cmd_accepted", {31'b0, done}, 32'd1);
        @(negedge pclk);
        cmd_valid = 1'b0;
    endtask

    // returns at the first negedge with rsp_valid high
    task automatic wait_rsp(output int pen_cycles, output int addr_moves);
        logic [31:0] a0;
        int n;
        a0 = paddr;
        pen_cycles = 0; addr_moves = 0; n = 0;
        while (!rsp_valid && n < 100) begin
            @(negedge pclk);
            n++;
            if (!rsp_valid && penable) begin
                pen_cycles++;
                if (paddr !== a0) addr_moves++;
            end
        end
        check("rsp_arrived", {31'b0, rsp_valid}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int pc, mv, seen;

        // reset
        repeat (3) @(negedge pclk);
        check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        check("rst_psel", {31'b0, psel}, 32'd0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_paddr", paddr, 32'd0);
        check("rst_state", {30'b0, dbg_state}, 32'd0);
        preset_n = 1'b1;
        cmd_valid2 = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h60;
        @(negedge pclk);
        check("post_rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        @(negedge pclk);
        cmd_valid2 = 1'b0;

        // 1: zero-wait write, exact latency
        cfg_wait = 0;
        send_cmd(1'b1, 32'h10, 32'hDEADBEEF);
        check("t1_setup_psel", {31'b0, psel}, 32'd1);
        check("t1_setup_penable", {31'b0, penable}, 32'd0);
        check("t1_setup_pwrite", {31'b0, pwrite}, 32'd1);
        check("t1_setup_paddr", paddr, 32'h10);
        check("t1_setup_pwdata", pwdata, 32'hDEADBEEF);
        check("t1_setup_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        @(negedge pclk);
        check("t1_access_penable", {31'b0, penable}, 32'd1);
        check("t1_access_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        @(negedge pclk);
        check("t1_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        check("t1_rsp_err", {31'b0, rsp_err}, 32'd0);
        check("t1_rsp_rdata", rsp_rdata, 32'd0);
        check("t1_rsp_psel", {31'b0, psel}, 32'd0);
        @(negedge pclk);
        check("t1_idle_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        check("t1_idle_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("t1_mem", mem[4], 32'hDEADBEEF);

        // 2: read with 3 wait states
        send_cmd(1'b1, 32'h10, 32'h12345678);
        wait_rsp(pc, mv);
        @(negedge pclk);
        cfg_wait = 3;
        send_cmd(1'b0, 32'h10, 32'hFFFFFFFF);
        check("t2_read_pwdata", pwdata, 32'd0);
        check("t2_read_pwrite", {31'b0, pwrite}, 32'd0);
        wait_rsp(pc, mv);
        check("t2_penable_cycles", pc, 32'd4);
        check("t2_paddr_moves", mv, 32'd0);
        check("t2_rdata", rsp_rdata, 32'h12345678);
        check("t2_err", {31'b0, rsp_err}, 32'd0);
        @(negedge pclk);

        // 3: pslverr
        cfg_wait = 1; cfg_err = 1'b1;
        send_cmd(1'b1, 32'h20, 32'h55);
        wait_rsp(pc, mv);
        check("t3_err", {31'b0, rsp_err}, 32'd1);
        check("t3_timeout", {31'b0, rsp_timeout}, 32'd0);
        check("t3_rdata", rsp_rdata, 32'd0);
        @(negedge pclk);
        cfg_err = 1'b0; cfg_wait = 0;

        // 4: timeout after exactly 16 ACCESS cycles; prdata nonzero but must not leak
        cfg_stall = 1'b1;
        send_cmd(1'b0, 32'h10, 32'h0);
        wait_rsp(pc, mv);
        check("t4_access_cycles", pc, 32'd16);
        check("t4_psel", {31'b0, psel}, 32'd0);
        check("t4_err", {31'b0, rsp_err}, 32'd1);
        check("t4_timeout", {31'b0, rsp_timeout}, 32'd1);
        check("t4_rdata", rsp_rdata, 32'd0);
        @(negedge pclk);
        cfg_stall = 1'b0;
        repeat (20) @(negedge pclk);
        check("t4_noto_psel", {31'b0, psel2}, 32'd1);
        check("t4_noto_penable", {31'b0, penable2}, 32'd1);
        check("t4_noto_rsp_valid", {31'b0, rsp_valid2}, 32'd0);

        // 5: response backpressure with a queued command
        rsp_ready = 1'b0;
        send_cmd(1'b0, 32'h10, 32'h0);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h44; cmd_wdata = 32'hA5A5A5A5;
        wait_rsp(pc, mv);
        for (int i = 0; i < 5; i++) begin
            check("t5_hold_rsp_valid", {31'b0, rsp_valid}, 32'd1);
            check("t5_hold_rdata", rsp_rdata, 32'h12345678);
            check("t5_hold_cmd_ready", {31'b0, cmd_ready}, 32'd0);
            check("t5_hold_psel", {31'b0, psel}, 32'd0);
            @(negedge pclk);
        end
        rsp_ready = 1'b1;
        @(negedge pclk);
        check("t5_after_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("t5_after_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        @(negedge pclk);
        cmd_valid = 1'b0;
        check("t5_q_psel", {31'b0, psel}, 32'd1);
        check("t5_q_pwrite", {31'b0, pwrite}, 32'd1);
        check("t5_q_paddr", paddr, 32'h44);
        check("t5_q_pwdata", pwdata, 32'hA5A5A5A5);
        wait_rsp(pc, mv);
        check("t5_q_err", {31'b0, rsp_err}, 32'd0);
        @(negedge pclk);
        check("t5_q_mem", mem[17], 32'hA5A5A5A5);

        // 6: reset during ACCESS
        cfg_stall = 1'b1;
        send_cmd(1'b0, 32'h10, 32'h0);
        @(negedge pclk);
        @(negedge pclk);
        check("t6_pre_penable", {31'b0, penable}, 32'd1);
        #2 preset_n = 1'b0;
        #1;
        check("t6_rst_psel", {31'b0, psel}, 32'd0);
        check("t6_rst_penable", {31'b0, penable}, 32'd0);
        check("t6_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("t6_rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        cfg_stall = 1'b0;
        @(negedge pclk);
        @(negedge pclk);
        preset_n = 1'b1;
        @(negedge pclk);
        check("t6_post_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid || psel) seen++;
            @(negedge pclk);
        end
        check("t6_no_activity", seen, 32'd0);

        // engine still usable after reset
        send_cmd(1'b0, 32'h10, 32'h0);
        wait_rsp(pc, mv);
        check("t6_read_after_rst", rsp_rdata, 32'h12345678);
        @(negedge pclk);

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
        $finish;
    end

endmodule
